// File: rtl/mac512_pkg.sv
// Shared constants and state encoding for the 512-bit MAC operand loader.
package mac512_pkg;

  localparam int OP_W       = 256;
  localparam int WORD_W     = 32;
  localparam int MAC_PERIOD = 257;
  localparam int NW         = OP_W / WORD_W;
  localparam int IDX_W      = $clog2(2 * NW);
  localparam int PC_W       = $clog2(MAC_PERIOD);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/operand_shadow_buf.sv
// Word-addressed shadow store for one A/B operand pair; words 0..NW-1 form A,
// NW..2*NW-1 form B, least-significant word first.
module operand_shadow_buf
  import mac512_pkg::*;
#(
  parameter int WORD_W = mac512_pkg::WORD_W,
  parameter int NW     = mac512_pkg::NW
) (
  input  logic                      clk,
  input  logic                      we_i,
  input  logic [$clog2(2*NW)-1:0]   idx_i,
  input  logic [WORD_W-1:0]         data_i,
  output logic [NW*WORD_W-1:0]      a_o,
  output logic [NW*WORD_W-1:0]      b_o
);

  localparam int BUF_IDX_W = $clog2(2 * NW);

  for (genvar gi = 0; gi < 2 * NW; gi++) begin : g_word
    logic [WORD_W-1:0] word_q;

    // Contents are don't-care until a full pair has been written, so no reset.
    always_ff @(posedge clk) begin
      if (we_i && (idx_i == BUF_IDX_W'(gi))) begin
        word_q <= data_i;
      end
    end

    if (gi < NW) begin : g_a
      assign a_o[gi*WORD_W +: WORD_W] = word_q;
    end else begin : g_b
      assign b_o[(gi-NW)*WORD_W +: WORD_W] = word_q;
    end
  end

endmodule

// File: rtl/mac_operand_loader.sv
// Streams operand words into a shadow pair and hands each pair to the MAC for
// exactly one enabled period, reloading back-to-back when the next pair is ready.
module mac_operand_loader
  import mac512_pkg::*;
#(
  parameter int WORD_W     = mac512_pkg::WORD_W,
  parameter int OP_W       = mac512_pkg::OP_W,
  parameter int MAC_PERIOD = mac512_pkg::MAC_PERIOD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic [OP_W-1:0]   a_out,
  output logic [OP_W-1:0]   b_out,
  output logic              mac_en,
  output logic              mac_done,
  output logic              busy,
  output logic [15:0]       pair_cnt
);

  localparam int NW    = OP_W / WORD_W;
  localparam int IDX_W = $clog2(2 * NW);
  localparam int PC_W  = $clog2(MAC_PERIOD);

  state_e             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [IDX_W-1:0]   idx_q;
  logic               pending_q;
  logic               s_ready_q;
  logic [OP_W-1:0]    a_q;
  logic [OP_W-1:0]    b_q;
  logic               mac_en_q;
  logic               mac_done_q;
  logic [15:0]        pair_cnt_q;

  logic               take_d;
  logic               last_word_d;
  logic               period_end_d;
  logic [OP_W-1:0]    shadow_a;
  logic [OP_W-1:0]    shadow_b;

  assign take_d       = s_valid && s_ready_q;
  assign last_word_d  = (idx_q == IDX_W'(2 * NW - 1));
  assign period_end_d = (pc_q == PC_W'(MAC_PERIOD - 1));

  operand_shadow_buf #(
    .WORD_W (WORD_W),
    .NW     (NW)
  ) u_shadow (
    .clk    (clk),
    .we_i   (take_d),
    .idx_i  (idx_q),
    .data_i (s_data),
    .a_o    (shadow_a),
    .b_o    (shadow_b)
  );

  // Pending is only set while s_ready is high and only cleared while it is
  // low, so the fill and hand-off branches never write it in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      s_ready_q  <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      mac_en_q   <= 1'b0;
      mac_done_q <= 1'b0;
      pair_cnt_q <= '0;
    end else begin
      mac_done_q <= 1'b0;

      if (take_d) begin
        if (last_word_d) begin
          idx_q     <= '0;
          pending_q <= 1'b1;
          s_ready_q <= 1'b0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (pending_q) begin
            a_q       <= shadow_a;
            b_q       <= shadow_b;
            pending_q <= 1'b0;
            s_ready_q <= 1'b1;
            pc_q      <= '0;
            mac_en_q  <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (period_end_d) begin
            mac_done_q <= 1'b1;
            pair_cnt_q <= pair_cnt_q + 16'd1;
            pc_q       <= '0;
            if (pending_q) begin
              // Reload on the wrap edge so the MAC's next load cycle sees the new pair.
              a_q       <= shadow_a;
              b_q       <= shadow_b;
              pending_q <= 1'b0;
              s_ready_q <= 1'b1;
            end else begin
              mac_en_q <= 1'b0;
              state_q  <= IDLE;
            end
          end else begin
            pc_q <= pc_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready  = s_ready_q;
  assign a_out    = a_q;
  assign b_out    = b_q;
  assign mac_en   = mac_en_q;
  assign mac_done = mac_done_q;
  assign pair_cnt = pair_cnt_q;
  assign busy     = (state_q == RUN) || pending_q;

endmodule

// File: tb/tb_mac_operand_loader.sv
// Directed bench for mac_operand_loader: vector table plus hand-written
// back-to-back, backpressure, late-arrival and reset sequences.
module tb_mac_operand_loader;
  import mac512_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic [OP_W-1:0]   a_out;
  logic [OP_W-1:0]   b_out;
  logic              mac_en;
  logic              mac_done;
  logic              busy;
  logic [15:0]       pair_cnt;

  mac_operand_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .a_out    (a_out),
    .b_out    (b_out),
    .mac_en   (mac_en),
    .mac_done (mac_done),
    .busy     (busy),
    .pair_cnt (pair_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Behavioural MAC model and activity monitor.
  int               en_cycles, done_pulses, takes, en_falls, period_pos, stab_err;
  logic             prev_en;
  logic [511:0]     acc;
  logic [OP_W-1:0]  prev_a, prev_b;
  logic [OP_W-1:0]  a_log[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      period_pos = 0;
      prev_en    = 1'b0;
    end else begin
      if (s_valid && s_ready) takes++;
      if (mac_done) done_pulses++;
      if (prev_en && !mac_en) en_falls++;
      prev_en = mac_en;
      if (mac_en) begin
        en_cycles++;
        if (period_pos == 0) begin
          acc = acc + (512'(a_out) * 512'(b_out));
          a_log.push_back(a_out);
        end else if (a_out !== prev_a || b_out !== prev_b) begin
          stab_err++;
        end
        prev_a = a_out;
        prev_b = b_out;
        period_pos = (period_pos == MAC_PERIOD - 1) ? 0 : period_pos + 1;
      end
    end
  end

  task automatic clear_mon();
    en_cycles = 0; done_pulses = 0; takes = 0; en_falls = 0; stab_err = 0;
    acc = '0;
    a_log.delete();
  endtask

  function automatic logic [2*OP_W-1:0] mk_pair(input logic [31:0] base);
    logic [2*OP_W-1:0] p;
    for (int i = 0; i < 2 * NW; i++) p[i*WORD_W +: WORD_W] = base + 32'(i);
    return p;
  endfunction

  task automatic send_words(input logic [2*OP_W-1:0] pair, input int first, input int last, input bit keep);
    for (int i = first; i <= last; i++) begin
      int guard;
      guard = 0;
      @(negedge clk);
      while (!s_ready && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (!s_ready) begin
        tests_run++;
        tests_failed++;
        $display("FAIL s_ready_timeout: got s_ready=%0b required 1", s_ready);
        s_valid = 1'b0;
        return;
      end
      s_valid = 1'b1;
      s_data  = pair[i*WORD_W +: WORD_W];
      @(posedge clk); #1;
    end
    if (!keep) s_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int g;
    g = 0;
    while (g < 600) begin
      @(posedge clk); #1;
      if (mac_done) break;
      g++;
    end
    chk(name, mac_done, 1'b1);
  endtask

  task automatic wait_pulses(input int n, input string name);
    int g;
    g = 0;
    while (done_pulses < n && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    chk(name, 32'(done_pulses), 32'(n));
  endtask

  task automatic wait_pos(input int pos, input string name);
    int g;
    g = 0;
    @(negedge clk);
    while (period_pos != pos && g < 600) begin
      @(negedge clk);
      g++;
    end
    chk(name, 32'(period_pos), 32'(pos));
  endtask

  typedef struct {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic [15:0]     exp_cnt;
  } vec_t;

  vec_t vecs[3];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    logic [2*OP_W-1:0] p;
    logic [2*OP_W-1:0] q;

    vecs[0] = '{a: 256'h3, b: 256'h5, exp_cnt: 16'd1};
    vecs[1] = '{a: {8{32'hFFFF_FFFF}},
                b: {32'h8765_4321, 192'h0, 32'h1234_5678}, exp_cnt: 16'd2};
    vecs[2] = '{a: 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001,
                b: 256'h00000018_00000017_00000016_00000015_00000014_00000013_00000012_00000011,
                exp_cnt: 16'd3};

    rst_n = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_a_out", a_out, '0);
    chk("rst_b_out", b_out, '0);
    chk("rst_mac_en", mac_en, 1'b0);
    chk("rst_mac_done", mac_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pair_cnt", pair_cnt, 16'd0);
    rst_n = 1'b1;

    // Single pairs from the vector table.
    for (int v = 0; v < 3; v++) begin
      clear_mon();
      send_words({vecs[v].b, vecs[v].a}, 0, 2 * NW - 1, 1'b0);
      chk($sformatf("v%0d_s_ready_drop", v), s_ready, 1'b0);
      chk($sformatf("v%0d_busy_pending", v), busy, 1'b1);
      chk($sformatf("v%0d_en_not_yet", v), mac_en, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_a_out", v), a_out, vecs[v].a);
      chk($sformatf("v%0d_b_out", v), b_out, vecs[v].b);
      chk($sformatf("v%0d_en_on", v), mac_en, 1'b1);
      chk($sformatf("v%0d_s_ready_back", v), s_ready, 1'b1);
      wait_done($sformatf("v%0d_done", v));
      chk($sformatf("v%0d_en_off", v), mac_en, 1'b0);
      chk($sformatf("v%0d_pair_cnt", v), pair_cnt, vecs[v].exp_cnt);
      chk($sformatf("v%0d_en_cycles", v), 32'(en_cycles), 32'd257);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_1cyc", v), mac_done, 1'b0);
      chk($sformatf("v%0d_idle", v), busy, 1'b0);
      chk($sformatf("v%0d_takes", v), 32'(takes), 32'd16);
      chk($sformatf("v%0d_stable", v), 32'(stab_err), 32'd0);
    end

    // Back-to-back: second pair loads while the first computes.
    clear_mon();
    send_words({256'h5, 256'h3}, 0, 2 * NW - 1, 1'b0);
    send_words({256'd11, 256'd7}, 0, 2 * NW - 1, 1'b0);
    wait_done("b2b_done1");
    chk("b2b_a_switch", a_out, 256'd7);
    chk("b2b_b_switch", b_out, 256'd11);
    chk("b2b_en_held", mac_en, 1'b1);
    chk("b2b_cnt1", pair_cnt, 16'd4);
    wait_done("b2b_done2");
    @(posedge clk); #1;
    chk("b2b_en_cycles", 32'(en_cycles), 32'd514);
    chk("b2b_en_falls", 32'(en_falls), 32'd1);
    chk("b2b_pulses", 32'(done_pulses), 32'd2);
    chk("b2b_cnt2", pair_cnt, 16'd5);
    chk("b2b_mac_acc", acc, 512'd92);
    chk("b2b_stable", 32'(stab_err), 32'd0);

    // Backpressure: s_valid high across three pairs.
    clear_mon();
    for (int k = 0; k < 3; k++) begin
      send_words(mk_pair(32'h100 * (k + 1)), 0, 2 * NW - 1, 1'b1);
      chk($sformatf("bp%0d_s_ready_low", k), s_ready, 1'b0);
    end
    s_valid = 1'b0;
    wait_pulses(3, "bp_pulses");
    chk("bp_takes", 32'(takes), 32'd48);
    chk("bp_en_cycles", 32'(en_cycles), 32'd771);
    chk("bp_en_falls", 32'(en_falls), 32'd1);
    chk("bp_cnt", pair_cnt, 16'd8);
    chk("bp_periods", 32'(a_log.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      p = mk_pair(32'h100 * (k + 1));
      if (k < a_log.size()) chk($sformatf("bp%0d_a", k), a_log[k], p[OP_W-1:0]);
    end

    // Late arrival: final word of pair 2 lands on the last enabled cycle.
    clear_mon();
    p = mk_pair(32'h1000);
    q = mk_pair(32'h2000);
    send_words(p, 0, 2 * NW - 1, 1'b0);
    send_words(q, 0, 2 * NW - 2, 1'b0);
    wait_pos(MAC_PERIOD - 1, "late_reach_pc");
    s_valid = 1'b1;
    s_data  = q[(2*NW-1)*WORD_W +: WORD_W];
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("late_done", mac_done, 1'b1);
    chk("late_bubble", mac_en, 1'b0);
    chk("late_pending", busy, 1'b1);
    @(posedge clk); #1;
    chk("late_en_back", mac_en, 1'b1);
    chk("late_a", a_out, q[OP_W-1:0]);
    chk("late_b", b_out, q[2*OP_W-1:OP_W]);
    wait_done("late_done2");
    @(posedge clk); #1;
    chk("late_en_falls", 32'(en_falls), 32'd2);
    chk("late_cnt", pair_cnt, 16'd10);

    // Reset mid-fill discards partial words.
    send_words(mk_pair(32'h3000), 0, 4, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rfill_a", a_out, '0);
    chk("rfill_cnt", pair_cnt, 16'd0);
    chk("rfill_s_ready", s_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p = mk_pair(32'h4000);
    send_words(p, 0, 2 * NW - 1, 1'b0);
    @(posedge clk); #1;
    chk("rfill_clean_a", a_out, p[OP_W-1:0]);
    chk("rfill_clean_b", b_out, p[2*OP_W-1:OP_W]);
    wait_done("rfill_done");
    chk("rfill_clean_cnt", pair_cnt, 16'd1);

    // Reset mid-run with a pair pending.
    p = mk_pair(32'h5000);
    send_words(p, 0, 2 * NW - 1, 1'b0);
    send_words(mk_pair(32'h5800), 0, 2 * NW - 1, 1'b0);
    wait_pos(100, "rrun_reach_pc");
    #2 rst_n = 1'b0;
    #1;
    chk("rrun_mac_en", mac_en, 1'b0);
    chk("rrun_a", a_out, '0);
    chk("rrun_b", b_out, '0);
    chk("rrun_busy", busy, 1'b0);
    chk("rrun_s_ready", s_ready, 1'b1);
    chk("rrun_cnt", pair_cnt, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rrun_no_restart", mac_en, 1'b0);
    p = mk_pair(32'h6000);
    send_words(p, 0, 2 * NW - 1, 1'b0);
    @(posedge clk); #1;
    chk("rrun_clean_a", a_out, p[OP_W-1:0]);
    chk("rrun_clean_b", b_out, p[2*OP_W-1:OP_W]);
    wait_done("rrun_done");
    chk("rrun_clean_cnt", pair_cnt, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
